bet_ledger: RTL

//   Sequential wager/bankroll stage for the baccarat datapath. Latches one bet (type, amount) per

---
 rtl/bet_ledger.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bet_ledger.sv
// Wager/bankroll stage: locks one bet per round, settles it against the round
// result and commits the new balance. Owns the authoritative bankroll.
module bet_ledger #(
   parameter logic [7:0] INIT_BALANCE = 8'd50,
   parameter int         TIE_MULT     = 8
) (
   input  logic       slow_clock,
   input  logic       reset,
   input  logic       bet_load,
   input  logic [1:0] bet_type,
   input  logic [7:0] bet_amount,
   input  logic       round_done,
   input  logic       dealerwin,
   input  logic       playerwin,
   output logic [7:0] balance,
   output logic [1:0] locked_type,
   output logic [7:0] locked_amount,
   output logic       bet_locked,
   output logic       bet_err,
   output logic       moneyerr,
   output logic       settled,
   output logic       broke,
   output logic [7:0] rounds
);

   typedef enum logic [1:0] {IDLE, LOCKED, SETTLE, BROKE} state_t;

   localparam logic [11:0] TIE_W = 12'(TIE_MULT);

   state_t      state, state_nxt;
   logic        dw_q, pw_q;
   logic        bet_ok, accept, reject;
   logic        tie, win, overflow;
   logic [11:0] ext_bal, ext_amt, result;
   logic [7:0]  commit_bal;

   assign bet_ok = (bet_type == 2'b00) ||
                   ((bet_amount != 8'd0) && (bet_amount <= balance));

   // Settlement is evaluated in 12 bits so a tie payout can be seen to overflow.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      ext_bal    = {4'd0, balance};
      ext_amt    = {4'd0, locked_amount};
      tie        = dw_q && pw_q;
      win        = (pw_q && !dw_q && locked_type == 2'b01) ||
                   (dw_q && !pw_q && locked_type == 2'b10);
      result     = ext_bal;
      if (locked_type == 2'b00)
         result = ext_bal;
      else if (tie)
         result = (locked_type == 2'b11) ? ext_bal + ext_amt * TIE_W : ext_bal;
      else if (win)
         result = ext_bal + ext_amt;
      else
         result = ext_bal - ext_amt;
      overflow   = |result[11:8];
      commit_bal = overflow ? balance : result[7:0];
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      reject    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bet_load) begin
               if (bet_ok) begin
                  accept    = 1'b1;
                  state_nxt = LOCKED;
               end else begin
                  reject    = 1'b1;
               end
            end
         end
         LOCKED: if (round_done) state_nxt = SETTLE;
         SETTLE: state_nxt = (commit_bal == 8'd0) ? BROKE : IDLE;
         BROKE:  state_nxt = BROKE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge slow_clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge slow_clock) begin
      if (reset) begin
         balance       <= INIT_BALANCE;
         locked_type   <= 2'b00;
         locked_amount <= 8'd0;
         bet_err       <= 1'b0;
         moneyerr      <= 1'b0;
         settled       <= 1'b0;
         rounds        <= 8'd0;
         dw_q          <= 1'b0;
         pw_q          <= 1'b0;
      end else begin
         settled <= 1'b0;
         if (accept) begin
            locked_type   <= bet_type;
            locked_amount <= (bet_type == 2'b00) ? 8'd0 : bet_amount;
            bet_err       <= 1'b0;
         end
         if (reject) bet_err <= 1'b1;
         if (state == LOCKED && round_done) begin
            dw_q <= dealerwin;
            pw_q <= playerwin;
         end
         if (state == SETTLE) begin
            balance  <= commit_bal;
            moneyerr <= overflow;
            rounds   <= rounds + 8'd1;
            settled  <= 1'b1;
         end
      end
   end

   assign bet_locked = (state == LOCKED) || (state == SETTLE);
   assign broke      = (state == BROKE);

endmodule
